// File: rtl/latch_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : latch_wr_sched
// Purpose  : Round-robin write scheduler for a shared-bus D-latch bank,
//            sequencing each write as setup / enable pulse / hold.
// Option   : LATCH_WR_SCHED_VERIFY_EN enables read-back check of q_i in HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module latch_wr_sched #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LAT   = 4,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 1,
  localparam int AW       = $clog2(NUM_LAT)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*AW-1:0]  addr_i,
  input  logic [NUM_REQ*DW-1:0]  wdata_i,
  input  logic [NUM_LAT*DW-1:0]  q_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic                   err_o,
  output logic [NUM_LAT-1:0]     latch_en_o,
  output logic [DW-1:0]          latch_d_o,
  output logic                   busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(EN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_win;
  logic [AW-1:0]        r_addr;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err;
  logic [NUM_LAT-1:0]   r_en;
  logic [DW-1:0]        r_d;
  logic                 r_busy;

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [PW:0]          w_sum;
  logic [PW-1:0]        w_win;
  logic [AW-1:0]        w_addr_sel;
  logic [DW-1:0]        w_wdata_sel;
  logic [NUM_REQ-1:0]   w_gnt_vec;
  logic [NUM_REQ-1:0]   w_ack_vec;
  logic [NUM_LAT-1:0]   w_en_vec;
  logic                 w_in_range;
  logic                 w_cnt_last;
  logic                 w_err;
  logic [PW-1:0]        w_ptr_nxt;

  // Rotate requests so bit i corresponds to requester (ptr + i) mod NUM_REQ.
  assign w_req2 = {req_i, req_i} >> r_ptr;
  assign w_rot  = w_req2[NUM_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
      end
    end
    w_win = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : PW'(w_sum);
  end

  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    w_gnt_vec   = '0;
    w_ack_vec   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_win == PW'(r)) begin
        w_addr_sel   = addr_i[r*AW +: AW];
        w_wdata_sel  = wdata_i[r*DW +: DW];
        w_gnt_vec[r] = 1'b1;
      end
      if (r_win == PW'(r)) begin
        w_ack_vec[r] = 1'b1;
      end
    end
  end

  assign w_in_range = ({1'b0, r_addr} < (AW+1)'(NUM_LAT));

  always_comb begin
    w_en_vec = '0;
    for (int k = 0; k < NUM_LAT; k++) begin
      w_en_vec[k] = w_in_range && (r_addr == AW'(k));
    end
  end

  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_ptr_nxt  = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);

`ifdef LATCH_WR_SCHED_VERIFY_EN
  // Sampled on the last enable cycle, while the latch is still transparent.
  logic [DW-1:0] w_q_sel;
  always_comb begin
    w_q_sel = '0;
    for (int k = 0; k < NUM_LAT; k++) begin
      if (r_addr == AW'(k)) begin
        w_q_sel = q_i[k*DW +: DW];
      end
    end
  end
  assign w_err = !w_in_range || (w_q_sel != r_d);
`else
  logic w_unused_q;
  assign w_unused_q = ^q_i;
  assign w_err      = !w_in_range;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_PULSE;
      S_PULSE: if (w_cnt_last) w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_win  <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_gnt  <= '0;
      r_ack  <= '0;
      r_err  <= 1'b0;
      r_en   <= '0;
      r_d    <= '0;
      r_busy <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_err  <= 1'b0;
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win  <= w_win;
            r_addr <= w_addr_sel;
            r_d    <= w_wdata_sel;
            r_gnt  <= w_gnt_vec;
            r_cnt  <= '0;
          end
        end
        S_SETUP: r_en <= w_en_vec;
        S_PULSE: begin
          if (w_cnt_last) begin
            r_en  <= '0;
            r_ack <= w_ack_vec;
            r_err <= w_err;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          r_gnt <= '0;
          r_ptr <= w_ptr_nxt;
        end
        default: r_en <= '0;
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign ack_o      = r_ack;
  assign err_o      = r_err;
  assign latch_en_o = r_en;
  assign latch_d_o  = r_d;
  assign busy_o     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_latch_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_wr_sched
// Purpose  : Self-checking bench for latch_wr_sched (two configurations:
//            defaults, and NUM_LAT=3 / EN_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_wr_sched;

`ifdef LATCH_WR_SCHED_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req   [2];
  logic [7:0]  addr  [2];
  logic [31:0] wdata [2];
  logic        corrupt [2];
  int          ck    [2];
  int          ptr   [2];
  logic [7:0]  last_d [2];

  logic [3:0]  gnt_a, ack_a, en_a;
  logic        err_a, busy_a;
  logic [7:0]  d_a;
  logic [31:0] q_a;
  logic [3:0]  gnt_b, ack_b;
  logic [2:0]  en_b;
  logic        err_b, busy_b;
  logic [7:0]  d_b;
  logic [23:0] q_b;
  logic [7:0]  mem_a [4];
  logic [7:0]  mem_b [3];

  int n_chk = 0;
  int n_err = 0;

  latch_wr_sched #(.NUM_REQ(4), .NUM_LAT(4), .DW(8), .EN_CYCLES(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
    .q_i(q_a), .gnt_o(gnt_a), .ack_o(ack_a), .err_o(err_a), .latch_en_o(en_a),
    .latch_d_o(d_a), .busy_o(busy_a));

  latch_wr_sched #(.NUM_REQ(4), .NUM_LAT(3), .DW(8), .EN_CYCLES(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
    .q_i(q_b), .gnt_o(gnt_b), .ack_o(ack_b), .err_o(err_b), .latch_en_o(en_b),
    .latch_d_o(d_b), .busy_o(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural latch bank: transparent while enabled, optionally forced to 0.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (en_a[k]) mem_a[k] <= d_a;
    for (int k = 0; k < 3; k++) if (en_b[k]) mem_b[k] <= d_b;
  end

  always_comb begin
    q_a = '0;
    q_b = '0;
    for (int k = 0; k < 4; k++)
      q_a[k*8 +: 8] = (corrupt[0] && ck[0] == k) ? 8'h00 : (en_a[k] ? d_a : mem_a[k]);
    for (int k = 0; k < 3; k++)
      q_b[k*8 +: 8] = (corrupt[1] && ck[1] == k) ? 8'h00 : (en_b[k] ? d_b : mem_b[k]);
  end

  function automatic logic [3:0] f_gnt(input int s);  return (s == 0) ? gnt_a : gnt_b; endfunction
  function automatic logic [3:0] f_ack(input int s);  return (s == 0) ? ack_a : ack_b; endfunction
  function automatic logic [3:0] f_en(input int s);   return (s == 0) ? en_a : {1'b0, en_b}; endfunction
  function automatic logic       f_err(input int s);  return (s == 0) ? err_a : err_b; endfunction
  function automatic logic       f_busy(input int s); return (s == 0) ? busy_a : busy_b; endfunction
  function automatic logic [7:0] f_d(input int s);    return (s == 0) ? d_a : d_b; endfunction

  // Round-robin reference: first requester at or after the pointer.
  function automatic int f_pick(input logic [3:0] rq, input int p);
    for (int i = 0; i < 4; i++) if (rq[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input int s);
    chk("idle_busy", f_busy(s), 0);
    chk("idle_gnt", f_gnt(s), 0);
    chk("idle_ack", f_ack(s), 0);
    chk("idle_err", f_err(s), 0);
    chk("idle_en", f_en(s), 0);
    chk("idle_d_hold", f_d(s), last_d[s]);
  endtask

  // One full transaction starting on an IDLE-cycle negedge.
  task automatic txn(input int s, input logic [3:0] rq, input logic [7:0] ad,
                     input logic [31:0] wd, input bit drop, input bit cor, input int hand_win);
    int w, a, nl, nen;
    logic [7:0] dv;
    logic oor, e;
    nl  = (s == 0) ? 4 : 3;
    nen = (s == 0) ? 1 : 3;
    @(negedge clk);
    req[1-s] = 4'b0;
    req[s]   = rq;
    addr[s]  = ad;
    wdata[s] = wd;
    w  = (hand_win >= 0) ? hand_win : f_pick(rq, ptr[s]);
    a  = int'(ad[w*2 +: 2]);
    dv = wd[w*8 +: 8];
    oor = (a >= nl);
    corrupt[s] = cor;
    ck[s] = a;
    e = oor | (VERIFY && cor && (dv != 8'h00));
    @(negedge clk);
    chk("setup_gnt", f_gnt(s), 32'(1) << w);
    chk("setup_d", f_d(s), dv);
    chk("setup_en", f_en(s), 0);
    chk("setup_busy", f_busy(s), 1);
    addr[s]  = ~ad;
    wdata[s] = ~wd;
    if (drop) req[s] = rq & ~(4'b1 << w);
    for (int c = 0; c < nen; c++) begin
      @(negedge clk);
      chk("pulse_en", f_en(s), oor ? 0 : (32'(1) << a));
      chk("pulse_ack", f_ack(s), 0);
      chk("pulse_d", f_d(s), dv);
    end
    @(negedge clk);
    chk("hold_en", f_en(s), 0);
    chk("hold_ack", f_ack(s), 32'(1) << w);
    chk("hold_err", f_err(s), e);
    chk("hold_gnt", f_gnt(s), 32'(1) << w);
    chk("hold_d", f_d(s), dv);
    ptr[s]     = (w + 1) % 4;
    last_d[s]  = dv;
    corrupt[s] = 1'b0;
  endtask

  typedef struct {
    int          s;
    logic [3:0]  rq;
    logic [7:0]  ad;
    logic [31:0] wd;
    bit          drop;
    bit          cor;
    int          win;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{0, 4'b1111, 8'hE4, 32'h44332211, 1'b0, 1'b0, 0};
    tbl[1]  = '{0, 4'b1111, 8'hE4, 32'h44332211, 1'b0, 1'b0, 1};
    tbl[2]  = '{0, 4'b1111, 8'hE4, 32'h44332211, 1'b0, 1'b0, 2};
    tbl[3]  = '{0, 4'b1111, 8'hE4, 32'h44332211, 1'b0, 1'b0, 3};
    tbl[4]  = '{0, 4'b1111, 8'hE4, 32'h44332211, 1'b0, 1'b0, 0};
    tbl[5]  = '{0, 4'b0001, 8'h02, 32'h000000A5, 1'b0, 1'b0, 0};
    tbl[6]  = '{0, 4'b0110, 8'h0C, 32'h00005A00, 1'b1, 1'b0, 1};
    tbl[7]  = '{0, 4'b0110, 8'h2C, 32'h00C35A00, 1'b0, 1'b0, 2};
    tbl[8]  = '{0, 4'b0110, 8'h2C, 32'h00C35A00, 1'b0, 1'b0, 1};
    tbl[9]  = '{0, 4'b0001, 8'h02, 32'h000000A5, 1'b0, 1'b1, 0};
    tbl[10] = '{0, 4'b0001, 8'h02, 32'h000000A5, 1'b0, 1'b0, 0};
    tbl[11] = '{1, 4'b0010, 8'h04, 32'h00003C00, 1'b0, 1'b0, 1};
    tbl[12] = '{1, 4'b0100, 8'h30, 32'h00770000, 1'b0, 1'b0, 2};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = '0; addr[s] = '0; wdata[s] = '0; corrupt[s] = 1'b0;
      ck[s] = 0; ptr[s] = 0; last_d[s] = 8'h00;
    end
    for (int k = 0; k < 4; k++) mem_a[k] = 8'h00;
    for (int k = 0; k < 3; k++) mem_b[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      txn(tbl[i].s, tbl[i].rq, tbl[i].ad, tbl[i].wd, tbl[i].drop, tbl[i].cor, tbl[i].win);
    @(negedge clk);
    req[0] = '0; req[1] = '0;
    chk_idle(0);
    chk_idle(1);

    // Reset during PULSE discards the write; pointer returns to 0.
    req[0] = 4'b1000; addr[0] = 8'h40; wdata[0] = 32'h99000000;
    @(negedge clk);
    chk("rst_seq_gnt", gnt_a, 4'b1000);
    @(negedge clk);
    chk("rst_seq_en", en_a, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_en", en_a, 0);
    chk("rst_gnt", gnt_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_d", d_a, 0);
    rst = 1'b0;
    req[0] = '0;
    @(negedge clk);
    chk("rst_no_ack", ack_a, 0);
    chk("rst_still_idle", busy_a, 0);
    ptr[0] = 0; ptr[1] = 0; last_d[0] = 8'h00; last_d[1] = 8'h00;
    txn(0, 4'b0011, 8'h06, 32'h0000BB11, 1'b0, 1'b0, 0);
    txn(0, 4'b0010, 8'h04, 32'h00007E00, 1'b0, 1'b0, 1);

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      int s;
      s = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req[0] = '0; req[1] = '0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("rand_gap_busy", f_busy(s), 0);
      end
      txn(s, 4'($urandom_range(1, 15)), 8'($urandom), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    @(negedge clk);
    req[0] = '0; req[1] = '0;
    @(negedge clk);
    chk_idle(0);
    chk_idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/latch_wr_sched.md
# latch_wr_sched

Write scheduler for a bank of level-sensitive D latches sharing one data bus. Arbitrates NUM_REQ requesters round-robin and sequences each winner's write as setup / enable-pulse / hold. No latch enable is ever asserted while the shared data bus changes. Sits between requesting logic and a `d_latch` bank (en_i/d_i per latch, q_o fed back).

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- NUM_LAT, 4, number of latch words in the bank (≥2)
- DW, 8, data width per latch word
- EN_CYCLES, 1, cycles latch enable stays high (≥1)
- AW, $clog2(NUM_LAT), address width (derived, not overridable)

Ports:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per-requester write request, level, held until ack_o
- addr_i  in  NUM_REQ*AW  packed addresses, slice r for requester r
- wdata_i  in  NUM_REQ*DW  packed write data, slice r for requester r
- q_i  in  NUM_LAT*DW  latch bank outputs, word k at slice k
- gnt_o  out  NUM_REQ  one-hot current owner, valid SETUP..HOLD
- ack_o  out  NUM_REQ  one-cycle write-complete pulse to owner
- err_o  out  1  one-cycle error pulse, coincident with ack_o
- latch_en_o  out  NUM_LAT  one-hot latch enables
- latch_d_o  out  DW  shared data bus to all latch d_i
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE: if any req_i, pick winner = first set bit at or after ptr (wrap mod NUM_REQ). Capture addr and wdata. Drive latch_d_o with the captured data. Set gnt_o. Go to SETUP.
  - SETUP (1 cycle): latch_en_o all 0. Go to PULSE.
  - PULSE (EN_CYCLES cycles, internal counter): latch_en_o[addr]=1. After the last cycle, go to HOLD.
  - HOLD (1 cycle): latch_en_o all 0. ack_o[winner]=1. err_o per the rules below. Set ptr=(winner+1) mod NUM_REQ. Go to IDLE. gnt_o clears on leaving HOLD.
- Captured address/data are frozen for the whole transaction. Requester changes to addr/wdata after grant have no effect.
- Dropping req_i after grant does not abort the transaction. ack_o is still issued.
- Out-of-range address (addr ≥ NUM_LAT): no latch_en_o bit ever asserts. Transaction still runs all states. err_o=1 in HOLD.
- latch_d_o holds its last value in IDLE. It changes only on the IDLE→SETUP transition.
- At most one latch_en_o bit is high in any cycle.
- All outputs are registered.
- Reset values: state IDLE, ptr 0, gnt_o 0, ack_o 0, err_o 0, latch_en_o 0, latch_d_o 0, busy_o 0.

## Timing
- Request seen high in IDLE at edge t:
  - SETUP, gnt_o and latch_d_o valid from t+1
  - latch_en_o high t+2 .. t+1+EN_CYCLES
  - HOLD and ack_o at t+2+EN_CYCLES
  - IDLE at t+3+EN_CYCLES
- A new grant is possible on the first IDLE cycle. Sustained throughput is one write per EN_CYCLES+3 cycles.
- Requests arriving during a transaction wait. Arbitration happens only in IDLE.
- Reset mid-transaction: outputs return to reset values the cycle after rst_i is sampled high. latch_en_o drops immediately. The transaction is discarded with no ack_o, and ptr returns to 0.
- The same requester cannot win twice in a row while another requester is pending.

## Configuration
- LATCH_WR_SCHED_VERIFY_EN defined: in HOLD, compare q_i word[addr] against captured data. Mismatch asserts err_o with ack_o. Out-of-range addresses still flag err_o.
- LATCH_WR_SCHED_VERIFY_EN undefined: q_i is ignored. err_o flags only out-of-range addresses.

## Test plan
- Defaults, req_i=4'b0001, addr0=2, wdata0=8'hA5 → latch_d_o=A5 at t+1, latch_en_o=4'b0100 at t+2 only, ack_o=4'b0001 at t+3, err_o=0, busy_o low at t+4.
- req_i=4'b1111 held, ptr=0 → grants in order 0,1,2,3,0 at 4-cycle spacing. Each ack_o matches gnt_o, no repeats.
- EN_CYCLES=3, req1 addr=1 data=3C → latch_en_o[1] high exactly 3 cycles. latch_d_o constant from SETUP through HOLD.
- NUM_LAT=3, addr=3 → latch_en_o stays 0 throughout. ack_o and err_o pulse together in HOLD.
- rst_i asserted during PULSE → next cycle latch_en_o=0, gnt_o=0, busy_o=0. No ack_o. The following request from requester 1 with ptr reset gets grant in one cycle.
- VERIFY_EN defined, bench forces q_i word2=00 while writing A5 → err_o=1 with ack_o. Correct q_i echo → err_o=0.
